image_mem: RTL and testbench

IMAGE_MEM -- requirements
Module: image_mem

---
 rtl/image_mem.sv | 143 ++++++++++++++
 tb/tb_image_mem.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/image_mem.sv
// image_mem: pixel image buffer built around one simple-dual-port RAM.
// Each write stores a whole word of DEPTH_NB pixels. Each read returns a group
// of GROUP_NB pixels through a three-register pipeline. There is no valid
// output: a consumer delays rd_val_1p by two more cycles to know when rd_data
// carries a fresh group.
//
// Pipeline timing, where edge N is the edge that samples rd_val/rd_addr:
//   edge N   : stage 1 registers rd_val_1p and the group select, and the RAM
//              registers the word address. The RAM array is sampled on this
//              same edge, so a write on edge N is not seen (read-first).
//   edge N+1 : stage 2 registers the RAM read word (RAM output register).
//   edge N+2 : stage 3 registers the selected group into rd_data.
// A request driven in the cycle before edge N therefore appears on rd_data
// three clock edges after it was launched. It stays there until the next group
// is loaded.

module image_mem #(
    parameter int DEPTH_NB   = 2,
    parameter int GROUP_NB   = 1,
    parameter int IMG_WIDTH  = 16,
    parameter int MEM_AWIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_val,
    input  logic [MEM_AWIDTH-1:0]         wr_addr,
    input  logic [IMG_WIDTH*DEPTH_NB-1:0] wr_data,
    input  logic                          rd_val,
    input  logic [MEM_AWIDTH-1:0]         rd_addr,
    output logic [GROUP_NB*IMG_WIDTH-1:0] rd_data
);

    // Derived geometry. GROUPS is the number of read groups in one word.
    localparam int WORD_W  = IMG_WIDTH * DEPTH_NB;
    localparam int GROUP_W = IMG_WIDTH * GROUP_NB;
    localparam int GROUPS  = DEPTH_NB / GROUP_NB;
    localparam int SHIFT   = $clog2(GROUPS);
    localparam int SEL_W   = (GROUPS > 1) ? SHIFT : 1;
    localparam int MEM_DEPTH = 2 ** MEM_AWIDTH;

    // Storage and pipeline registers.
    logic [WORD_W-1:0]     mem [0:MEM_DEPTH-1];
    logic [WORD_W-1:0]     ram_q;       // RAM read word, registered at edge N
    logic [WORD_W-1:0]     ram_q_2p;    // RAM output register (stage 2)
    logic                  rd_val_1p;
    logic                  rd_val_2p;
    logic [SEL_W-1:0]      sel_1p;
    logic [SEL_W-1:0]      sel_2p;

    // Address split: upper bits select the word, low bits select the group.
    logic [MEM_AWIDTH-1:0] rd_word;
    logic [SEL_W-1:0]      rd_sel;
    logic [GROUP_W-1:0]    group_sel;

    // The word index is rd_addr / GROUPS. Shifting a MEM_AWIDTH-bit address
    // can only produce indices inside the RAM, so the top bits that fall off
    // the word-index range are simply not used.
    assign rd_word = rd_addr >> SHIFT;

    generate
        if (GROUPS > 1) begin : g_multi_group
            assign rd_sel = rd_addr[SEL_W-1:0];
        end else begin : g_single_group
            // One group per word, so the select is always group 0.
            assign rd_sel = '0;
        end
    endgenerate

    // RAM port: whole-word write, plus a registered read on the request edge.
    // The write and the read are in the same block, and the read sees the
    // contents from before this edge. That makes the RAM read-first.
    // NOTE: the memory array has no reset. Clearing 2**MEM_AWIDTH words is
    // not possible in one edge, it would stop the RAM mapping to block RAM, and
    // the image contents must survive a reset anyway.
    always_ff @(posedge clk) begin
        if (wr_val && !rst) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_val) begin
            ram_q <= mem[rd_word];
        end
    end

    // Stage 1: request valid and group select, cleared by reset.
    // NOTE: every sequential assignment is non-blocking (<=). All registers
    // then update together from values sampled before the edge, which keeps
    // the pipeline stages one cycle apart in both simulation and hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_val_1p <= 1'b0;
            sel_1p    <= '0;
        end else begin
            rd_val_1p <= rd_val;
            if (rd_val) begin
                sel_1p <= rd_sel;
            end
        end
    end

    // Stage 2 control: carry the valid and the select alongside the RAM word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_val_2p <= 1'b0;
            sel_2p    <= '0;
        end else begin
            rd_val_2p <= rd_val_1p;
            if (rd_val_1p) begin
                sel_2p <= sel_1p;
            end
        end
    end

    // Stage 2 data: RAM output register. It has no reset, so it can be the
    // block RAM's own output register.
    always_ff @(posedge clk) begin
        if (!rst && rd_val_1p) begin
            ram_q_2p <= ram_q;
        end
    end

    // Group multiplexer: pick pixels [sel*GROUP_NB +: GROUP_NB] of the word.
    // NOTE: group_sel gets a default before the loop, so every path assigns it
    // and no latch is inferred.
    always_comb begin
        group_sel = '0;
        for (int g = 0; g < GROUPS; g++) begin
            if (sel_2p == SEL_W'(g)) begin
                group_sel = ram_q_2p[g*GROUP_W +: GROUP_W];
            end
        end
    end

    // Stage 3: load a fresh group only for a live request. Otherwise hold the
    // last value. Reset clears the output and drops any request in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_val_2p) begin
            rd_data <= group_sel;
        end
    end

endmodule

// File: tb/tb_image_mem.sv
// tb_image_mem: directed and random stimulus for image_mem in its default
// configuration. The reference model treats the RAM as an array of 32-bit
// words and treats the read path as a list of pending results, each due two
// edges after its request is sampled.
// Every cycle, rd_data and rd_val_1p are compared with the model on the
// falling edge.

module tb_image_mem;

    localparam int DEPTH_NB   = 2;
    localparam int GROUP_NB   = 1;
    localparam int IMG_WIDTH  = 16;
    localparam int MEM_AWIDTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_val;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic        rd_val;
    logic [15:0] rd_addr;
    logic [15:0] rd_data;

    image_mem #(
        .DEPTH_NB   (DEPTH_NB),
        .GROUP_NB   (GROUP_NB),
        .IMG_WIDTH  (IMG_WIDTH),
        .MEM_AWIDTH (MEM_AWIDTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_val  (wr_val),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_val  (rd_val),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    // Reference model state.
    typedef struct {
        int          due;   // edge count at which rd_data takes the value
        logic [15:0] val;
    } pend_t;

    logic [31:0] model [int];
    pend_t       pend [$];
    int          edge_cnt = 0;
    logic [15:0] exp_data = '0;
    logic        exp_v1   = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Pixel value stored at group address a. The word is a / 2, and the lane
    // is a % 2, where lane 0 is the low pixel.
    function automatic logic [15:0] pixel_at(input int a);
        logic [31:0] w;
        w = model[a / 2];
        return 16'((w >> (16 * (a % 2))) & 32'hFFFF);
    endfunction

    // One clock: update the model at the rising edge, then compare on the
    // falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        edge_cnt++;
        if (rst) begin
            pend.delete();
            exp_data = '0;
            exp_v1   = 1'b0;
        end else begin
            while (pend.size() > 0 && pend[0].due == edge_cnt) begin
                exp_data = pend[0].val;
                void'(pend.pop_front());
            end
            exp_v1 = rd_val;
            if (rd_val) begin
                // Read-first: the value is taken before this edge's write lands.
                pend.push_back('{due: edge_cnt + 2, val: pixel_at(int'(rd_addr))});
            end
            if (wr_val) begin
                model[int'(wr_addr)] = wr_data;
            end
        end
        @(negedge clk);
        n_checks++;
        assert (rd_data === exp_data) else begin
            n_fail++;
            $error("FAIL %s rd_data: got %h expected %h (edge %0d)", tag, rd_data, exp_data, edge_cnt);
        end
        n_checks++;
        assert (dut.rd_val_1p === exp_v1) else begin
            n_fail++;
            $error("FAIL %s rd_val_1p: got %b expected %b (edge %0d)", tag, dut.rd_val_1p, exp_v1, edge_cnt);
        end
    endtask

    // Explicit constant check, for the cases the model alone should not
    // vouch for.
    task automatic expect_data(input string tag, input logic [15:0] want);
        n_checks++;
        assert (rd_data === want) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, rd_data, want);
        end
    endtask

    initial begin
        rst = 1'b1; wr_val = 1'b0; wr_addr = '0; wr_data = '0;
        rd_val = 1'b0; rd_addr = '0;

        // Reset for 6 cycles.
        for (int i = 0; i < 6; i++) tick("reset");
        expect_data("reset_zero", 16'h0000);
        rst = 1'b0;

        // Fill words 0..10 with {2k+1, 2k}; rd_data must stay at 0.
        for (int k = 0; k <= 10; k++) begin
            wr_val = 1'b1; wr_addr = 16'(k); wr_data = {16'(2*k + 1), 16'(2*k)};
            tick("fill");
        end
        wr_val = 1'b0;
        tick("fill_idle");
        expect_data("fill_no_change", 16'h0000);

        // Back-to-back reads 0..10, then drain.
        for (int a = 0; a <= 10; a++) begin
            rd_val = 1'b1; rd_addr = 16'(a);
            tick("seq_read");
        end
        rd_val = 1'b0;
        for (int i = 0; i < 3; i++) tick("seq_drain");
        expect_data("seq_last", 16'd10);

        // Even addresses, then odd addresses.
        for (int a = 0; a <= 10; a += 2) begin
            rd_val = 1'b1; rd_addr = 16'(a); tick("even_read");
        end
        for (int a = 1; a <= 11; a += 2) begin
            rd_val = 1'b1; rd_addr = 16'(a); tick("odd_read");
        end
        rd_val = 1'b0;
        for (int i = 0; i < 3; i++) tick("eo_drain");
        expect_data("odd_last", 16'd11);

        // Ten random reads in 0..15.
        for (int i = 0; i < 10; i++) begin
            rd_val = 1'b1; rd_addr = 16'($urandom_range(0, 15)); tick("rand_read");
        end
        rd_val = 1'b0;
        for (int i = 0; i < 3; i++) tick("rand_drain");

        // Same-edge write and read of word 3: the old pixel 6 comes back, and
        // the next read sees 99.
        wr_val = 1'b1; wr_addr = 16'd3; wr_data = {16'd0, 16'd99};
        rd_val = 1'b1; rd_addr = 16'd6;
        tick("rw_same_edge");
        wr_val = 1'b0;
        tick("rw_reread");
        rd_val = 1'b0;
        tick("rw_wait");
        expect_data("rw_old_value", 16'd6);
        tick("rw_wait2");
        expect_data("rw_new_value", 16'd99);

        // Reset with reads in flight and a write presented: the reads are
        // dropped, and the write is ignored.
        for (int a = 1; a <= 3; a++) begin
            rd_val = 1'b1; rd_addr = 16'(a); tick("pre_reset_read");
        end
        rd_val = 1'b1; rd_addr = 16'd5;
        rst = 1'b1; wr_val = 1'b1; wr_addr = 16'd4; wr_data = 32'hDEAD_BEEF;
        tick("mid_reset");
        rst = 1'b0; wr_val = 1'b0; rd_val = 1'b0;
        for (int i = 0; i < 4; i++) tick("post_reset_idle");
        expect_data("no_stale", 16'h0000);

        // RAM contents survive reset, and the ignored write did not land.
        rd_val = 1'b1; rd_addr = 16'd8; tick("survive_read");
        rd_val = 1'b0;
        tick("survive_wait");
        tick("survive_wait2");
        expect_data("survive_word4", 16'd8);

        // Random mixed traffic on words 0..10: reads and writes are
        // independent.
        for (int i = 0; i < 200; i++) begin
            wr_val  = 1'($urandom_range(0, 1));
            wr_addr = 16'($urandom_range(0, 10));
            wr_data = $urandom;
            rd_val  = 1'($urandom_range(0, 1));
            rd_addr = 16'($urandom_range(0, 21));
            tick("mixed");
        end
        wr_val = 1'b0; rd_val = 1'b0;
        for (int i = 0; i < 5; i++) tick("final_hold");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
